// File: rtl/fetch_unit_pkg.sv
// Shared encodings and widths for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] FETCH_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        FETCH_BOOT  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_FAULT = 2'd2
    } fetch_state_e;

    // A fetch target is legal only when it sits on a word boundary.
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Instruction buffer: a pc tag queue filled at request time and a
// {pc, instr} FIFO filled when the matching response returns.
module fetch_buf
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tag_push,
    input  logic [XLEN-1:0]         tag_pc,
    input  logic                    push,
    input  logic [ILEN-1:0]         instr,
    input  logic                    pop,
    input  logic                    flush,
    input  logic                    keep_head,
    output logic [XLEN-1:0]         head_pc,
    output logic [ILEN-1:0]         head_instr,
    output logic [$clog2(DEPTH):0]  occ
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] pc_mem_d    [DEPTH];
    logic [ILEN-1:0] instr_mem_q [DEPTH];
    logic [ILEN-1:0] instr_mem_d [DEPTH];
    logic [XLEN-1:0] tag_mem_q   [DEPTH];
    logic [XLEN-1:0] tag_mem_d   [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic            pop_ok_s;

    // Next-state for both queues; a flush empties everything, optionally
    // retiring the head that decode is taking in the same cycle.
    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        tag_mem_d   = tag_mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        tag_rd_d    = tag_rd_q;
        tag_wr_d    = tag_wr_q;
        occ_d       = occ_q;
        pop_ok_s    = pop && (occ_q != {CW{1'b0}});

        if (tag_push) begin
            tag_mem_d[tag_wr_q] = tag_pc;
        end else begin
            tag_mem_d = tag_mem_q;
        end

        if (flush) begin
            rd_ptr_d = rd_ptr_q + AW'(keep_head && pop_ok_s);
            wr_ptr_d = rd_ptr_d;
            tag_rd_d = {AW{1'b0}};
            tag_wr_d = {AW{1'b0}};
            occ_d    = {CW{1'b0}};
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]    = tag_mem_q[tag_rd_q];
                instr_mem_d[wr_ptr_q] = instr;
            end else begin
                pc_mem_d    = pc_mem_q;
                instr_mem_d = instr_mem_q;
            end
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop_ok_s);
            tag_wr_d = tag_wr_q + AW'(tag_push);
            tag_rd_d = tag_rd_q + AW'(push);
            occ_d    = occ_q + CW'(push) - CW'(pop_ok_s);
        end
    end

    // Storage and pointer registers; contents clear so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= {XLEN{1'b0}};
                instr_mem_q[i] <= {ILEN{1'b0}};
                tag_mem_q[i]   <= {XLEN{1'b0}};
            end
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            tag_rd_q <= {AW{1'b0}};
            tag_wr_q <= {AW{1'b0}};
            occ_q    <= {CW{1'b0}};
        end else begin
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
            tag_mem_q   <= tag_mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            tag_rd_q    <= tag_rd_d;
            tag_wr_q    <= tag_wr_d;
            occ_q       <= occ_d;
        end
    end

    assign head_pc    = pc_mem_q[rd_ptr_q];
    assign head_instr = instr_mem_q[rd_ptr_q];
    assign occ        = occ_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited
// memory requests, discards stale responses after a redirect and
// traps misaligned redirect targets.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
    parameter int          BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] npc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    input  logic        id_ready,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    localparam int CW  = $clog2(BUF_DEPTH) + 1;
    localparam int CWP = CW + 1;
    localparam logic [CW:0]   DEPTH_C = CWP'(BUF_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1'b1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outs_q, outs_d, drop_q, drop_d;
    logic          fault_q, fault_d;
    logic [31:0]   fault_pc_q, fault_pc_d;

    logic [CW-1:0] occ_s;
    logic          credit_s, req_fire_s, rsp_ok_s, redir_s, aligned_s;
    logic          push_s, pop_s, keep_head_s;

    // Request credit, response accounting, PC update and FSM next state.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        outs_d      = outs_q;
        drop_d      = drop_q;
        fault_d     = fault_q;
        fault_pc_d  = fault_pc_q;

        credit_s       = ({1'b0, occ_s} + {1'b0, outs_q}) < DEPTH_C;
        imem_req_valid = (state_q == FETCH_RUN) && !redirect && credit_s;
        req_fire_s     = imem_req_valid && imem_req_ready;
        rsp_ok_s       = imem_rsp_valid && (outs_q != {CW{1'b0}});
        redir_s        = redirect && (state_q == FETCH_RUN);
        aligned_s      = is_word_aligned(npc);
        pop_s          = id_valid && id_ready;
        keep_head_s    = redir_s && aligned_s && pop_s;
        push_s         = rsp_ok_s && (drop_q == {CW{1'b0}}) && !redir_s
                         && (state_q == FETCH_RUN);

        outs_d = outs_q + CW'(req_fire_s) - CW'(rsp_ok_s);

        // Everything still in flight at a redirect belongs to the old path.
        if (redir_s) begin
            drop_d = outs_q - CW'(rsp_ok_s);
        end else if (rsp_ok_s && (drop_q != {CW{1'b0}})) begin
            drop_d = drop_q - ONE_C;
        end else begin
            drop_d = drop_q;
        end

        if (redir_s && aligned_s) begin
            pc_d = npc;
        end else if (req_fire_s) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end

        case (state_q)
            FETCH_BOOT: begin
                state_d = FETCH_RUN;
            end
            FETCH_RUN: begin
                if (redir_s && !aligned_s) begin
                    state_d    = FETCH_FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = npc;
                end else begin
                    state_d = FETCH_RUN;
                end
            end
            FETCH_FAULT: begin
                state_d = FETCH_FAULT;
            end
            default: begin
                state_d = FETCH_BOOT;
            end
        endcase
    end

    // Architectural fetch state and fault capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_BOOT;
            pc_q       <= RESET_PC;
            outs_q     <= {CW{1'b0}};
            drop_q     <= {CW{1'b0}};
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            outs_q     <= outs_d;
            drop_q     <= drop_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .tag_push   (req_fire_s),
        .tag_pc     (pc_q),
        .push       (push_s),
        .instr      (imem_rsp_data),
        .pop        (pop_s),
        .flush      (redir_s),
        .keep_head  (keep_head_s),
        .head_pc    (id_pc),
        .head_instr (id_instr),
        .occ        (occ_s)
    );

    assign imem_req_addr = pc_q;
    assign id_valid      = (occ_s != {CW{1'b0}});
    assign fetch_fault   = fault_q;
    assign fault_pc      = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] npc = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready = 1'b0;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int cyc = 0;
    int lat = 1;
    int c0 = 0;
    int n_assert = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t req_log[$];
    ev_t id_log[$];
    ev_t pend[$];

    fetch_unit #(
        .RESET_PC  (32'h0000_3000),
        .BUF_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect       (redirect),
        .npc            (npc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_ready       (id_ready),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory returns addr + 0x1000_0000 after lat cycles; also logs handshakes.
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            pend.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else begin
            imem_rsp_valid = 1'b0;
            if (pend.size() > 0 && pend[0].cyc == cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend[0].a + 32'h1000_0000;
                void'(pend.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                e.cyc = cyc + lat; e.a = imem_req_addr; e.d = 32'h0;
                pend.push_back(e);
                e.cyc = cyc;
                req_log.push_back(e);
            end
            if (id_valid && id_ready) begin
                e.cyc = cyc; e.a = id_pc; e.d = id_instr;
                id_log.push_back(e);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic hold_reset(input logic rdy, input int l);
        rst_n = 1'b0; redirect = 1'b0; npc = 32'h0;
        id_ready = rdy; imem_req_ready = 1'b1; lat = l;
        run(2);
    endtask

    // Releases reset; the cycle in which this returns is cycle 0.
    task automatic release_reset();
        tick();
        rst_n = 1'b1;
        c0 = cyc;
        req_log.delete();
        id_log.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        // ---- reset values and basic streaming, 1-cycle memory ----
        hold_reset(1'b1, 1);
        #1;
        chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h0000_3000);
        chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        release_reset();
        #1;
        chk("boot_no_req", {31'h0, imem_req_valid}, 32'h0);
        run(10);
        chk("s1_req0_addr", req_log[0].a, 32'h0000_3000);
        chk("s1_req0_cyc", 32'(req_log[0].cyc - c0), 32'd1);
        chk("s1_req1_addr", req_log[1].a, 32'h0000_3004);
        chk("s1_req2_addr", req_log[2].a, 32'h0000_3008);
        chk("s1_id0_cyc", 32'(id_log[0].cyc - c0), 32'd3);
        chk("s1_id0_pc", id_log[0].a, 32'h0000_3000);
        chk("s1_id0_instr", id_log[0].d, 32'h1000_3000);
        chk("s1_id1_cyc", 32'(id_log[1].cyc - c0), 32'd4);
        chk("s1_id5_pc", id_log[5].a, 32'h0000_3014);
        chk("s1_id5_cyc", 32'(id_log[5].cyc - c0), 32'd8);

        // ---- decode stalled: credit limits fetch to four words ----
        hold_reset(1'b0, 1);
        release_reset();
        run(10);
        chk("s2_req_count", 32'(req_log.size()), 32'd4);
        chk("s2_req3_addr", req_log[3].a, 32'h0000_300C);
        chk("s2_req_stalled", {31'h0, imem_req_valid}, 32'h0);
        chk("s2_id_valid", {31'h0, id_valid}, 32'h1);
        chk("s2_id_pc_hold", id_pc, 32'h0000_3000);
        id_ready = 1'b1;
        run(8);
        chk("s2_id0_pc", id_log[0].a, 32'h0000_3000);
        chk("s2_id0_cyc", 32'(id_log[0].cyc - c0), 32'd10);
        chk("s2_id3_pc", id_log[3].a, 32'h0000_300C);
        chk("s2_id4_pc", id_log[4].a, 32'h0000_3010);
        chk("s2_resume_addr", req_log[4].a, 32'h0000_3010);

        // ---- 3-cycle memory, redirect with 2 in flight and 1 buffered ----
        hold_reset(1'b0, 3);
        release_reset();
        tick();                                 // cycle 1: request 0x3000
        tick(); imem_req_ready = 1'b0;          // cycle 2: memory busy
        tick(); imem_req_ready = 1'b1;          // cycle 3: request 0x3004
        tick();                                 // cycle 4: request 0x3008
        tick(); imem_req_ready = 1'b0;          // cycle 5: redirect
        redirect = 1'b1; npc = 32'h0000_4000;
        #1;
        chk("s3_pre_reqs", 32'(req_log.size()), 32'd3);
        chk("s3_pre_id_valid", {31'h0, id_valid}, 32'h1);
        chk("s3_pre_id_pc", id_pc, 32'h0000_3000);
        chk("s3_req_blocked", {31'h0, imem_req_valid}, 32'h0);
        tick();                                 // cycle 6
        redirect = 1'b0; npc = 32'h0; imem_req_ready = 1'b1; id_ready = 1'b1;
        #1;
        chk("s3_flushed", {31'h0, id_valid}, 32'h0);
        chk("s3_req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("s3_req_addr", imem_req_addr, 32'h0000_4000);
        run(8);
        chk("s3_id0_pc", id_log[0].a, 32'h0000_4000);
        chk("s3_id0_instr", id_log[0].d, 32'h1000_4000);
        chk("s3_id1_pc", id_log[1].a, 32'h0000_4004);

        // ---- redirect in the cycle the delay slot is accepted ----
        hold_reset(1'b1, 1);
        release_reset();
        run(3);                                 // cycle 3
        tick(); id_ready = 1'b0;                // cycle 4
        tick();                                 // cycle 5
        redirect = 1'b1; npc = 32'h0000_4000; id_ready = 1'b1;
        #1;
        chk("s4_slot_pc", id_pc, 32'h0000_3004);
        tick();                                 // cycle 6
        redirect = 1'b0; npc = 32'h0;
        #1;
        chk("s4_flushed", {31'h0, id_valid}, 32'h0);
        chk("s4_req_addr", imem_req_addr, 32'h0000_4000);
        run(4);
        chk("s4_slot_taken", id_log[1].a, 32'h0000_3004);
        chk("s4_slot_cyc", 32'(id_log[1].cyc - c0), 32'd5);
        chk("s4_target_pc", id_log[2].a, 32'h0000_4000);

        // ---- misaligned redirect raises a sticky fault ----
        hold_reset(1'b1, 1);
        release_reset();
        run(4);
        redirect = 1'b1; npc = 32'h0000_4002;
        tick();
        redirect = 1'b0; npc = 32'h0;
        #1;
        chk("s5_fault", {31'h0, fetch_fault}, 32'h1);
        chk("s5_fault_pc", fault_pc, 32'h0000_4002);
        chk("s5_id_valid", {31'h0, id_valid}, 32'h0);
        req_log.delete();
        run(20);
        chk("s5_no_reqs", 32'(req_log.size()), 32'd0);
        redirect = 1'b1; npc = 32'h0000_5000;
        tick();
        redirect = 1'b0; npc = 32'h0;
        run(3);
        chk("s5_ignored_reqs", 32'(req_log.size()), 32'd0);
        chk("s5_fault_pc_hold", fault_pc, 32'h0000_4002);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_fault", {31'h0, fetch_fault}, 32'h0);
        chk("s5_rst_fault_pc", fault_pc, 32'h0);

        // ---- asynchronous reset mid-stream with three entries buffered ----
        hold_reset(1'b0, 1);
        release_reset();
        run(5);
        chk("s6_id_valid", {31'h0, id_valid}, 32'h1);
        chk("s6_id_instr", id_instr, 32'h1000_3000);
        #1;
        rst_n = 1'b0;
        #1;
        chk("s6_async_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("s6_async_req_addr", imem_req_addr, 32'h0000_3000);
        chk("s6_async_id_valid", {31'h0, id_valid}, 32'h0);
        chk("s6_async_id_pc", id_pc, 32'h0);
        chk("s6_async_id_instr", id_instr, 32'h0);
        run(2);
        release_reset();
        id_ready = 1'b1;
        run(4);
        chk("s6_req0_addr", req_log[0].a, 32'h0000_3000);
        chk("s6_req0_cyc", 32'(req_log[0].cyc - c0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS pipeline. Holds the architectural fetch PC, issues word-aligned requests to instruction memory over a valid/ready handshake, and buffers in-order responses in a small FIFO. It presents {pc, instr} pairs to decode over a second valid/ready handshake and accepts redirect targets produced by the next-PC logic in decode, flushing younger fetches.

## Interface
- RESET_PC, 32'h0000_3000, fetch address after reset.
- BUF_DEPTH, 4, instruction buffer entries and maximum in-flight-plus-buffered fetches; power of two, ≥2.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redirect  in  1  one-cycle pulse from decode: next fetch comes from npc.
- npc  in  32  redirect target, valid only while redirect=1.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch word address.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response valid; responses are in order, latency ≥1 cycle, never back-pressured.
- imem_rsp_data  in  32  instruction word.
- id_valid  out  1  buffer head valid toward decode.
- id_pc  out  32  PC of head instruction.
- id_instr  out  32  head instruction.
- id_ready  in  1  decode consumes head.
- fetch_fault  out  1  sticky misaligned-redirect fault.
- fault_pc  out  32  offending target.

## Operation
- FSM states: BOOT, RUN, FAULT. Reset enters BOOT. BOOT → RUN after one cycle, with no request issued in BOOT. RUN → FAULT on redirect with npc[1:0]≠0. FAULT is left only by reset.
- Registers: pc_q, outs (in-flight count), drop (responses still to discard), buffer occupancy occ. Counters are $clog2(BUF_DEPTH)+1 bits wide.
- Request rule: imem_req_valid = (state==RUN) && !redirect && (occ + outs < BUF_DEPTH), evaluated on registered values. imem_req_addr = pc_q.
- On a request handshake: pc_q ← pc_q+4 (32-bit wrap) and outs increments.
- Response handling: each imem_rsp_valid decrements outs. If drop>0, the response is discarded and drop decrements. Otherwise {pc, data} is pushed to the buffer. The pc for each response is queued at request time in a BUF_DEPTH-deep pc tag FIFO inside the buffer.
- Decode handshake: id_valid = occ≠0. On id_valid && id_ready the head is popped.
- Redirect with aligned target:
  - pc_q ← npc.
  - Every buffered entry is flushed, except the head when id_valid && id_ready in the same cycle. That head is the delay slot and is consumed normally.
  - drop ← outs minus any response arriving this cycle, so all in-flight responses are discarded.
  - Decode must assert redirect in the cycle it accepts the delay-slot instruction, or later.
- Redirect with misaligned target: fetch_fault ← 1, fault_pc ← npc, buffer flushed, in-flight responses dropped, no further requests.
- Redirect in BOOT is ignored. Redirect in FAULT is ignored.
- Simultaneous push and pop: both take effect, and occ is unchanged.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr = RESET_PC, id_valid 0, id_pc 0, id_instr 0, fetch_fault 0, fault_pc 0, pc_q RESET_PC, outs/drop/occ 0.
- Assertion of rst_n clears all state immediately. Responses arriving while rst_n=0 are ignored. Memory must be reset together with this block.
- With 1-cycle memory and id_ready=1 after reset release at cycle 0:
  - cycle 1: first request.
  - cycle 2: first response.
  - cycle 3: id_valid=1 with id_pc=RESET_PC.
  - Thereafter one instruction per cycle.
- Response to id_valid: buffer outputs are registered, so a pushed entry is visible the cycle after the response.
- Redirect to first new request: the request for npc issues the cycle after redirect, provided credit is available.

## Structure
- Shared control-encoding defines header gets:
  - FETCH_BOOT/RUN/FAULT state codes.
  - Default RESET_PC.
  - Instruction and address width defines.
- Sub-module fetch_buf: a synchronous FIFO of BUF_DEPTH entries, {pc, instr} wide.
  - Ports: push, pop, flush, keep_head.
  - Outputs: head, occ.
  - Holds the pc tag queue.
- fetch_unit holds the FSM, pc_q, and the outs/drop counters.

## Test plan
- Reset release, 1-cycle memory, id_ready=1 → requests 0x3000, 0x3004, 0x3008…; id_valid first at cycle 3 with id_pc=0x3000; one instruction per cycle thereafter.
- id_ready=0 → exactly 4 requests (0x3000–0x300C), then imem_req_valid=0; id_pc holds 0x3000. Raise id_ready → 0x3000–0x300C delivered in order, fetch resumes at 0x3010.
- 3-cycle memory latency, redirect npc=0x4000 with 2 in flight and 1 buffered (no pop) → both late responses discarded, next request 0x4000, next id_pc=0x4000.
- Redirect npc=0x4000 in the same cycle that id handshakes 0x3004 → 0x3004 consumed, 0x3008 flushed, next delivered id_pc=0x4000.
- Redirect npc=0x4002 → fetch_fault=1 and fault_pc=0x4002 next cycle; id_valid=0; no requests for 20 cycles; reset clears fault.
- rst_n low mid-stream with occ=3 → outputs at reset values without a clock edge; after release, first request is 0x3000 at cycle 1.
